// File: rtl/pipe_mem_arb_pkg.sv
// Shared types and limits for the pipeline memory arbiter.
// Grant state encoding and counter sizing live here so RTL and bench agree.
package pipe_mem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   localparam int LAT_MIN = 1;
   localparam int LAT_MAX = 8;
   localparam int CNT_W   = 3;

endpackage

// File: rtl/pipe_mem_arb_if.sv
// Fetch port, MEM-stage port and memory port of the shared-memory arbiter.
// Requests are levels held until their one-cycle done pulse; a misaligned data
// request is answered in the same cycle with done+err and never reaches memory.
interface pipe_mem_arb_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        i_done;
   logic        i_stall;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        d_err;
   logic        d_stall;

   logic        ram_en;
   logic        ram_we;
   logic [29:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      output i_rdata, i_done, i_stall, d_rdata, d_done, d_err, d_stall,
      output ram_en, ram_we, ram_addr, ram_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
      input  i_rdata, i_done, i_stall, d_rdata, d_done, d_err, d_stall,
      input  ram_en, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/pipe_mem_arb.sv
// Arbiter/sequencer giving fetch and MEM stage turns on one fixed-latency
// single-port memory, with stall generation and a saturating stall counter.
module pipe_mem_arb
   import pipe_mem_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic          clock,
   input  logic          reset,
   pipe_mem_arb_if.slave bus,
   output logic [31:0]   stall_cycles,
   output state_t        state
);

   if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_check
      $error("pipe_mem_arb: LAT must be within 1..8");
   end

   logic [CNT_W-1:0] cnt;
   logic             last_d;
   logic             last_cyc;
   logic             d_mis;
   logic             d_ok;
   logic             grant_d;
   logic             grant_i;
   logic             unused_addr_bits;

   assign unused_addr_bits = &{1'b0, bus.i_addr[1:0]};

   assign last_cyc = (cnt == '0);
   assign d_mis    = bus.d_req & (bus.d_addr[1:0] != 2'b00);
   assign d_ok     = bus.d_req & ~d_mis;

   // On a conflict the requester that did not win last time goes first.
   assign grant_d  = d_ok & (~bus.i_req | ~last_d);
   assign grant_i  = bus.i_req & ~grant_d;

   assign bus.i_done  = (state == BUSY_I) & last_cyc;
   assign bus.d_err   = (state == IDLE) & d_mis;
   assign bus.d_done  = ((state == BUSY_D) & last_cyc) | bus.d_err;
   assign bus.i_rdata = bus.i_done ? bus.ram_rdata : 32'h0;
   assign bus.d_rdata = ((state == BUSY_D) & last_cyc & ~bus.ram_we) ? bus.ram_rdata : 32'h0;
   assign bus.i_stall = bus.i_req & ~bus.i_done;
   assign bus.d_stall = bus.d_req & ~bus.d_done;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         last_d        <= 1'b0;
         bus.ram_en    <= 1'b0;
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= '0;
         bus.ram_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state         <= BUSY_D;
                  cnt           <= CNT_W'(LAT - 1);
                  last_d        <= 1'b1;
                  bus.ram_en    <= 1'b1;
                  bus.ram_we    <= bus.d_we;
                  bus.ram_addr  <= bus.d_addr[31:2];
                  bus.ram_wdata <= bus.d_wdata;
               end else if (grant_i) begin
                  state        <= BUSY_I;
                  cnt          <= CNT_W'(LAT - 1);
                  last_d       <= 1'b0;
                  bus.ram_en   <= 1'b1;
                  bus.ram_we   <= 1'b0;
                  bus.ram_addr <= bus.i_addr[31:2];
               end
            end
            BUSY_I, BUSY_D: begin
               // Memory port stays frozen until the final busy cycle.
               if (last_cyc) begin
                  state      <= IDLE;
                  bus.ram_en <= 1'b0;
                  bus.ram_we <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if ((bus.i_stall | bus.d_stall) && (stall_cycles != 32'hFFFF_FFFF)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: doc/pipe_mem_arb.md
# pipe_mem_arb

Arbiter and sequencer for one shared single-port, fixed-latency memory used by both the instruction-fetch stage and the MEM stage of the pipelined computer. It grants the memory to one requester at a time and drives the memory port for exactly LAT cycles per access. It returns read data with a one-cycle done pulse, and produces the stall signals that freeze the pipeline while an access is pending. It also maintains a stall-cycle performance counter.

## Interface
- LAT, 2: memory access latency in cycles; legal range 1..8.
- clock  in  1  pipeline clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  fetch request; level, held until i_done.
- i_addr  in  32  fetch byte address; stable while i_req is high.
- i_rdata  out  32  fetched instruction; valid only when i_done=1.
- i_done  out  1  one-cycle fetch completion pulse.
- i_stall  out  1  combinational: i_req & ~i_done.
- d_req  in  1  MEM-stage request; level, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid only when d_done=1.
- d_done  out  1  one-cycle data completion pulse; also asserted for a misaligned request.
- d_err  out  1  one-cycle pulse, misaligned d_addr (d_addr[1:0]≠0).
- d_stall  out  1  combinational: d_req & ~d_done.
- ram_en  out  1  memory enable; registered.
- ram_we  out  1  memory write enable; registered.
- ram_addr  out  30  word address; registered.
- ram_wdata  out  32  registered write data.
- ram_rdata  in  32  memory read data; valid in the last busy cycle.
- stall_cycles  out  32  count of cycles in which i_stall or d_stall was high.

## Operation
- States: IDLE, BUSY_I, BUSY_D. A 3-bit down-counter `cnt` tracks the remaining busy cycles. A `last_d` flag records the previous grant.
- IDLE arbitration, evaluated on every IDLE cycle:
  - d_req alone: grant D.
  - i_req alone: grant I.
  - Both requests with last_d=0: grant D.
  - Both requests with last_d=1: grant I.
  - This gives round-robin on conflict.
- Misaligned D request in IDLE: no grant, no memory access. d_done=1 and d_err=1 combinationally in that cycle, d_rdata=0, state stays IDLE.
- On a grant:
  - Next state is BUSY_I or BUSY_D, and cnt is loaded with LAT-1.
  - ram_en=1, ram_addr=addr[31:2]. For D, ram_we=d_we and ram_wdata=d_wdata. For I, ram_we=0.
  - last_d is set to 1 if D was granted, else 0.
- BUSY_x: ram_* outputs are held constant and cnt decrements each cycle.
- When cnt==0:
  - x_done=1 and x_rdata=ram_rdata (for a store, d_rdata=0).
  - Next state is IDLE, and ram_en and ram_we are cleared.
- A request that drops while it is granted is a protocol violation. The access still completes and the done pulse is still issued.
- stall_cycles increments by 1 in every cycle with (i_stall|d_stall), saturates at 0xFFFF_FFFF, and is never cleared except by reset.

## Timing
- Reset (applied at any time, including mid-access):
  - State returns to IDLE; cnt=0, last_d=0.
  - All outputs are 0, including ram_en, ram_we, ram_addr, ram_wdata, the done/err pulses, rdata and stall_cycles.
  - An in-flight access is abandoned with no done pulse.
- Access latency:
  - Request granted in IDLE cycle t.
  - ram_en is high during cycles t+1 .. t+LAT.
  - x_done is asserted in cycle t+LAT.
  - x_stall is high in cycles t .. t+LAT-1.
- Earliest next grant is t+LAT+1, because IDLE lasts at least one cycle. Back-to-back accesses are therefore LAT+1 cycles apart.
- A requester waiting during another's access keeps its stall high throughout. When both requesters conflict, a single access takes 2·(LAT+1) cycles in the worst case.
- LAT=1: a single busy cycle, with cnt loaded with 0. Done occurs at t+1.
- Misaligned D: completes in the same cycle (zero latency) with no stall.

## Structure
- Package pipe_mem_pkg:
  - State enum {IDLE, BUSY_I, BUSY_D}.
  - LAT_MIN=1, LAT_MAX=8.
  - CNT_W=3.
- The RTL checks LAT range at elaboration.
- Single module, with no sub-module. The saturating stall counter is inline logic.

## Test plan
- Lone load, LAT=2: d_req=1, d_we=0, d_addr=0x0000_0010 at t, memory returns 0xDEAD_BEEF.
  - ram_addr=0x4 and ram_en=1 during t+1..t+2.
  - d_done and d_rdata=0xDEAD_BEEF at t+2; d_stall=1 during t..t+1.
  - stall_cycles=2.
- Lone store, LAT=3: d_addr=0x20, d_wdata=0x1234_5678.
  - ram_we=1, ram_addr=0x8 and ram_wdata=0x1234_5678 during t+1..t+3.
  - d_done at t+3 with d_rdata=0.
- Conflict, LAT=2, last_d=0: i_req and d_req both rise at t.
  - D is granted at t with d_done at t+2.
  - I is granted at t+3 with i_done at t+5.
  - i_stall is high during t..t+4.
- Round-robin: immediately after a D access completes, both requests are asserted. I is granted first.
- Misaligned load: d_addr=0x0000_0013.
  - d_done=1 and d_err=1 in the same cycle.
  - ram_en stays 0 and the state stays IDLE.
- Reset mid-access, LAT=4: reset is asserted at t+2 of an I access.
  - Next cycle: ram_en=0, state IDLE, stall_cycles=0.
  - No i_done pulse is ever issued for that access.
